edge_packer: RTL and testbench
==============================

EDGE_PACKER -- requirements
Module: edge_packer

Interface
REQ-001 Parameter IMG_W, 256, pixels per image row (1..1024).
REQ-002 Parameter FIFO_DEPTH, 4, output byte FIFO entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, asynchronous and active-high.
REQ-005 enb  input  1  edge bit valid; edge_in is sampled when high.
REQ-006 edge_in  input  1  edge flag from the edge-detection stage (1 = edge).
REQ-007 frame_end  input  1  single-cycle pulse marking the end of the image stream (driven by upstream complete).
REQ-008 byte_ready  input  1  consumer accepts byte_out this cycle.
REQ-009 byte_out  output  8  packed edge bits; bit 0 = earliest pixel.
REQ-010 byte_valid  output  1  byte_out holds valid data (FIFO not empty).
REQ-011 edge_count  output  16  total edge bits seen this frame; saturates at 16'hFFFF.
REQ-012 done  output  1  frame fully packed and drained.
REQ-013 overflow  output  1  sticky: a byte was dropped because the FIFO was full.

Function
REQ-014 FSM states IDLE, PACK, FLUSH, DONE; the state register SHALL be the only control state besides counters.
REQ-015 IDLE -> PACK on the first enb=1; in that cycle the bit SHALL be packed.
REQ-016 In PACK each enb=1 SHALL write edge_in into shift-register bit bit_idx, increment bit_idx and column counter col.
REQ-017 A byte SHALL be pushed when bit_idx reaches 7 or col reaches IMG_W-1; unused upper bits SHALL be 0; bit_idx SHALL reset to 0, and col SHALL wrap to 0 at IMG_W-1 (row boundary always starts a new byte).
REQ-018 byte_valid SHALL assert the cycle after the bit completing a byte is sampled (1-cycle latency), when the FIFO was empty.
REQ-019 Handshake: a byte SHALL be popped on byte_valid & byte_ready; byte_out SHALL remain stable while byte_valid=1 and byte_ready=0.
REQ-020 Push into a full FIFO with no simultaneous pop SHALL drop the byte and set overflow; simultaneous push and pop on a full FIFO SHALL succeed.
REQ-021 edge_count SHALL increment on enb & edge_in, holding at 16'hFFFF.
REQ-022 frame_end in PACK -> FLUSH; when frame_end and enb coincide, the bit SHALL be packed first and included in the flush byte.
REQ-023 FLUSH SHALL push the partial byte if bit_idx != 0 (one cycle), then wait until the FIFO is empty, then -> DONE.
REQ-024 DONE SHALL hold done=1; enb ignored; next enb after frame_end deasserted SHALL not restart; only reset returns to IDLE.
REQ-025 frame_end in IDLE SHALL go directly to DONE with no bytes pushed.
REQ-026 enb in FLUSH SHALL be ignored.

Reset
REQ-027 On reset: state=IDLE, bit_idx=0, col=0, FIFO empty, byte_out=0, byte_valid=0, edge_count=0, done=0, overflow=0.
REQ-028 Reset asserted mid-frame SHALL discard all pending bits and FIFO contents immediately, with no byte emitted after release until new input.

Structure
REQ-029 Shared package holds the FSM state encoding (2 bits) and the default IMG_W/FIFO_DEPTH constants.
REQ-030 The FIFO SHALL be a sub-module edge_byte_fifo (parameterised width 8, depth FIFO_DEPTH, full/empty flags).
REQ-031 Counter widths SHALL be $clog2-derived from IMG_W and FIFO_DEPTH.

Verification
REQ-032 IMG_W=8, byte_ready=1, 8 bits 1,0,1,1,0,0,0,1 then frame_end -> one byte 8'h8D, edge_count=4, done=1.
REQ-033 IMG_W=10, 10 bits all 1 then frame_end -> bytes 8'hFF then 8'h03, edge_count=10.
REQ-034 byte_ready=0, FIFO_DEPTH=4, 40 bits (5 bytes) -> 4 bytes held, overflow=1; raise byte_ready -> exactly 4 bytes in order.
REQ-035 5 bits 1 with frame_end on the 5th enb cycle -> one byte 8'h1F, done after drain.
REQ-036 Reset pulse after 3 bits -> byte_valid=0, edge_count=0; then 8 zero bits + frame_end -> single byte 8'h00.
REQ-037 Hold byte_ready=0 for 3 cycles with byte_valid=1 -> byte_out unchanged each cycle.

Source files
------------

// File: rtl/edge_packer_pkg.sv
// Shared types and default sizing for the edge bit packer.
package edge_packer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PACK  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int DEF_IMG_W      = 256;
   localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/edge_byte_fifo.sv
// Small synchronous FIFO holding packed edge bytes; head is shown combinationally.
module edge_byte_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [PW:0]      count;
   logic             wr_en, rd_en;

   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;
   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign dout  = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         if (wr_en && !rd_en)      count <= count + 1'b1;
         else if (!wr_en && rd_en) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/edge_packer.sv
// Packs a stream of per-pixel edge flags into bytes (LSB = earliest pixel),
// starting a fresh byte at every row boundary, and buffers them for a consumer.
module edge_packer
   import edge_packer_pkg::*;
#(
   parameter int IMG_W      = DEF_IMG_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enb,
   input  logic        edge_in,
   input  logic        frame_end,
   input  logic        byte_ready,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   output logic [15:0] edge_count,
   output logic        done,
   output logic        overflow
);

   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

   state_t           state, state_nxt;
   logic [2:0]       bit_idx, bit_idx_nxt;
   logic [COL_W-1:0] col, col_nxt;
   logic [7:0]       sreg, sreg_nxt;
   logic [7:0]       packed_byte, push_byte;
   logic             push, take, byte_end, pop;
   logic             fifo_full, fifo_empty;

   assign byte_valid = !fifo_empty;
   assign pop        = byte_valid && byte_ready;
   assign done       = (state == DONE);

   always_comb begin
      state_nxt   = state;
      bit_idx_nxt = bit_idx;
      col_nxt     = col;
      sreg_nxt    = sreg;
      push        = 1'b0;
      push_byte   = sreg;
      take        = 1'b0;
      packed_byte = sreg;
      packed_byte[bit_idx] = edge_in;
      byte_end    = (bit_idx == 3'd7) || (col == COL_LAST);
      case (state)
         IDLE, PACK: begin
            take = enb;
            if (enb) begin
               if (byte_end) begin
                  push        = 1'b1;
                  push_byte   = packed_byte;
                  sreg_nxt    = '0;
                  bit_idx_nxt = '0;
               end else begin
                  sreg_nxt    = packed_byte;
                  bit_idx_nxt = bit_idx + 3'd1;
               end
               col_nxt   = (col == COL_LAST) ? '0 : col + 1'b1;
               state_nxt = PACK;
            end
            // A coincident bit is packed above, so it lands in the flush byte.
            if (frame_end) state_nxt = (state == IDLE && !enb) ? DONE : FLUSH;
         end
         FLUSH: begin
            if (bit_idx != 3'd0) begin
               push        = 1'b1;
               push_byte   = sreg;
               sreg_nxt    = '0;
               bit_idx_nxt = '0;
            end else if (fifo_empty) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         bit_idx    <= '0;
         col        <= '0;
         sreg       <= '0;
         edge_count <= '0;
         overflow   <= 1'b0;
      end else begin
         state   <= state_nxt;
         bit_idx <= bit_idx_nxt;
         col     <= col_nxt;
         sreg    <= sreg_nxt;
         if (take && edge_in && edge_count != 16'hFFFF) edge_count <= edge_count + 16'd1;
         if (push && fifo_full && !pop) overflow <= 1'b1;
      end
   end

   edge_byte_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (push_byte),
      .dout  (byte_out),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_edge_packer.sv
// Scoreboard bench driving two packers (row widths 8 and 10) with identical stimulus.
module tb_edge_packer;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic enb = 1'b0, edge_in = 1'b0, frame_end = 1'b0, byte_ready = 1'b0;

   logic [7:0]  out8, out10;
   logic        vld8, vld10, done8, done10, ovf8, ovf10;
   logic [15:0] cnt8, cnt10;

   int total = 0;
   int bad = 0;
   logic [7:0] q8[$];
   logic [7:0] q10[$];

   always #5 clk = ~clk;

   edge_packer #(.IMG_W(8), .FIFO_DEPTH(4)) u_w8 (
      .clk(clk), .reset(reset), .enb(enb), .edge_in(edge_in), .frame_end(frame_end),
      .byte_ready(byte_ready), .byte_out(out8), .byte_valid(vld8), .edge_count(cnt8),
      .done(done8), .overflow(ovf8));

   edge_packer #(.IMG_W(10), .FIFO_DEPTH(4)) u_w10 (
      .clk(clk), .reset(reset), .enb(enb), .edge_in(edge_in), .frame_end(frame_end),
      .byte_ready(byte_ready), .byte_out(out10), .byte_valid(vld10), .edge_count(cnt10),
      .done(done10), .overflow(ovf10));

   // Every accepted byte must match the head of its instance's expectation queue.
   always @(negedge clk) begin
      if (vld8 && byte_ready) begin
         total++;
         if (q8.size() == 0) begin
            bad++; $display("FAIL pop8 unexpected byte got=%h want=none", out8);
         end else begin
            logic [7:0] e8;
            e8 = q8.pop_front();
            if (out8 !== e8) begin bad++; $display("FAIL pop8 got=%h want=%h", out8, e8); end
         end
      end
      if (vld10 && byte_ready) begin
         total++;
         if (q10.size() == 0) begin
            bad++; $display("FAIL pop10 unexpected byte got=%h want=none", out10);
         end else begin
            logic [7:0] e10;
            e10 = q10.pop_front();
            if (out10 !== e10) begin bad++; $display("FAIL pop10 got=%h want=%h", out10, e10); end
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic send_bit(input logic b, input logic fe);
      enb = 1'b1; edge_in = b; frame_end = fe;
      @(posedge clk); #1;
      enb = 1'b0; edge_in = 1'b0; frame_end = 1'b0;
   endtask

   task automatic send_frame_end();
      frame_end = 1'b1;
      @(posedge clk); #1;
      frame_end = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!(done8 && done10) && n < 60) begin @(posedge clk); #1; n++; end
      total++;
      if (!(done8 && done10)) begin
         bad++; $display("FAIL %s done timeout got=%b%b want=11", name, done8, done10);
      end
   endtask

   task automatic check_drained(input string name);
      total++;
      if (q8.size() != 0 || q10.size() != 0) begin
         bad++; $display("FAIL %s pending got=%0d/%0d want=0/0", name, q8.size(), q10.size());
      end
   endtask

   task automatic check_count(input string name, input logic [15:0] want);
      total++;
      if (cnt8 !== want || cnt10 !== want) begin
         bad++; $display("FAIL %s edge_count got=%0d/%0d want=%0d", name, cnt8, cnt10, want);
      end
   endtask

   task automatic test_reset();
      #2 reset = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({vld8, vld10, done8, done10, ovf8, ovf10} !== 6'b0 || out8 !== 8'h00 || out10 !== 8'h00 ||
          cnt8 !== 16'd0 || cnt10 !== 16'd0) begin
         bad++;
         $display("FAIL reset outs got vld=%b%b done=%b%b ovf=%b%b out=%h/%h cnt=%0d/%0d want all zero",
                  vld8, vld10, done8, done10, ovf8, ovf10, out8, out10, cnt8, cnt10);
      end
      reset = 1'b0;
   endtask

   task automatic test_single_byte();
      logic [7:0] bits;
      bits = 8'b1000_1101;
      do_reset();
      byte_ready = 1'b1;
      q8.push_back(8'h8D); q10.push_back(8'h8D);
      for (int i = 0; i < 8; i++) send_bit(bits[i], 1'b0);
      send_frame_end();
      wait_done("single");
      check_count("single", 16'd4);
      check_drained("single");
   endtask

   task automatic test_row_wrap();
      do_reset();
      byte_ready = 1'b1;
      q8.push_back(8'hFF); q8.push_back(8'h03);
      q10.push_back(8'hFF); q10.push_back(8'h03);
      for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0);
      send_frame_end();
      wait_done("row_wrap");
      check_count("row_wrap", 16'd10);
      check_drained("row_wrap");
   endtask

   task automatic test_frame_end_with_enb();
      do_reset();
      byte_ready = 1'b1;
      q8.push_back(8'h1F); q10.push_back(8'h1F);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b1);
      wait_done("fe_enb");
      check_count("fe_enb", 16'd5);
      check_drained("fe_enb");
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      byte_ready = 1'b1;
      for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
      do_reset();
      total++;
      if (vld8 !== 1'b0 || vld10 !== 1'b0 || cnt8 !== 16'd0 || cnt10 !== 16'd0) begin
         bad++; $display("FAIL midreset got vld=%b%b cnt=%0d/%0d want vld=00 cnt=0", vld8, vld10, cnt8, cnt10);
      end
      repeat (3) @(posedge clk);
      #1;
      q8.push_back(8'h00); q10.push_back(8'h00);
      for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b0);
      send_frame_end();
      wait_done("midreset");
      check_count("midreset", 16'd0);
      check_drained("midreset");
   endtask

   task automatic test_backpressure();
      logic [39:0] stream;
      int n;
      stream = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
      do_reset();
      byte_ready = 1'b0;
      q8.push_back(8'h11); q8.push_back(8'h22); q8.push_back(8'h33); q8.push_back(8'h44);
      q10.push_back(8'h11); q10.push_back(8'h02); q10.push_back(8'hC8); q10.push_back(8'h00);
      for (int i = 0; i < 40; i++) send_bit(stream[i], 1'b0);
      total++;
      if (ovf8 !== 1'b1 || ovf10 !== 1'b1 || vld8 !== 1'b1 || vld10 !== 1'b1) begin
         bad++; $display("FAIL bp_overflow got ovf=%b%b vld=%b%b want 11/11", ovf8, ovf10, vld8, vld10);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++;
         if (out8 !== 8'h11 || out10 !== 8'h11) begin
            bad++; $display("FAIL hold cycle %0d got=%h/%h want=11/11", c, out8, out10);
         end
      end
      @(posedge clk); #1;
      byte_ready = 1'b1;
      n = 0;
      while ((q8.size() != 0 || q10.size() != 0) && n < 30) begin @(posedge clk); #1; n++; end
      check_drained("bp_drain");
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (vld8 !== 1'b0 || vld10 !== 1'b0 || ovf8 !== 1'b1) begin
         bad++; $display("FAIL bp_after got vld=%b%b ovf8=%b want vld=00 ovf8=1", vld8, vld10, ovf8);
      end
      send_frame_end();
      wait_done("bp");
   endtask

   task automatic test_idle_frame_end();
      do_reset();
      byte_ready = 1'b1;
      send_frame_end();
      total++;
      if (done8 !== 1'b1 || done10 !== 1'b1 || vld8 !== 1'b0 || vld10 !== 1'b0) begin
         bad++; $display("FAIL idle_fe got done=%b%b vld=%b%b want done=11 vld=00", done8, done10, vld8, vld10);
      end
      for (int i = 0; i < 9; i++) send_bit(1'b1, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (done8 !== 1'b1 || done10 !== 1'b1 || vld8 !== 1'b0 || vld10 !== 1'b0) begin
         bad++; $display("FAIL done_hold got done=%b%b vld=%b%b want done=11 vld=00", done8, done10, vld8, vld10);
      end
      check_drained("idle_fe");
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_row_wrap();
      test_frame_end_with_enb();
      test_reset_mid_frame();
      test_backpressure();
      test_idle_frame_end();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
